alu_seq: RTL and testbench

- Parametrised, handshaked successor of the single-cycle 32-bit datapath ALU; width N is generic.
- Extends the op set to the RV32I integer ops: xor, set-less-than signed/unsigned, and shifts.
- Optionally adds iterative multiply/divide, which completes in N cycles.
- Sits in the EX stage; the pipeline holds the stage while in_ready=0 or while a result is pending.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 85 ++++++++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and mul/div op classification for alu_seq
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // One bit per op code; set for the ops handled by the iterative unit
  localparam logic [15:0] MULDIV_OPS = 16'h3C00;

  function automatic logic op_is_muldiv(input alu_op_t op);
    return MULDIV_OPS[op];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - radix-2 iterative multiply (shift-add) and restoring divide, N steps
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  alu_op_t      op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);

  alu_op_t       r_op;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_hi;
  logic [N-1:0]  r_lo;
  logic [CW-1:0] r_cnt;
  logic          r_active;

  logic          w_is_div;
  logic          w_ge;
  logic [N:0]    w_sum;
  logic [N:0]    w_rsh;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_hi_n;
  logic [N-1:0]  w_lo_n;

  // {r_hi,r_lo} is the 2N product accumulator for mul, {remainder,quotient} for div
  always_comb begin
    w_is_div = (r_op == OP_DIVU) || (r_op == OP_REMU);
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_rsh    = {r_hi, r_lo[N-1]};
    w_ge     = w_rsh >= {1'b0, r_b};
    w_diff   = w_rsh[N-1:0] - r_b;
    if (w_is_div) begin
      w_hi_n = w_ge ? w_diff : w_rsh[N-1:0];
      w_lo_n = {r_lo[N-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[N:1];
      w_lo_n = {w_sum[0], r_lo[N-1:1]};
    end
    case (r_op)
      OP_MUL, OP_DIVU:  result = w_lo_n;
      OP_MULHU, OP_REMU: result = w_hi_n;
      default:          result = '0;
    endcase
    done = r_active && (r_cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_op     <= op;
      r_a      <= a;
      r_b      <= b;
      r_hi     <= '0;
      r_lo     <= ((op == OP_DIVU) || (op == OP_REMU)) ? a : b;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + CW'(1);
      if (done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked EX-stage ALU; define ALU_SEQ_MULDIV_EN for iterative mul/div
module alu_seq
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] SrcA,
  input  logic [N-1:0] SrcB,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUResult,
  output logic         zero_flag,
  output logic         busy
);

  alu_state_t     r_state;
  logic [N-1:0]   r_result;
  logic           r_zero;
  logic           r_out_valid;

  alu_op_t        w_op;
  logic           w_accept;
  logic           w_go_busy;
  logic [SHW-1:0] w_shamt;
  logic [N-1:0]   w_simple;

  assign w_op     = alu_op_t'(ALUControl);
  assign w_shamt  = SrcB[SHW-1:0];
  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_simple = '0;
    case (w_op)
      OP_ADD:  w_simple = SrcA + SrcB;
      OP_SUB:  w_simple = SrcA - SrcB;
      OP_AND:  w_simple = SrcA & SrcB;
      OP_OR:   w_simple = SrcA | SrcB;
      OP_XOR:  w_simple = SrcA ^ SrcB;
      OP_SLT:  w_simple = {{(N-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: w_simple = {{(N-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL:  w_simple = SrcA << w_shamt;
      OP_SRL:  w_simple = SrcA >> w_shamt;
      OP_SRA:  w_simple = $signed(SrcA) >>> w_shamt;
      default: w_simple = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic         w_md_done;
  logic [N-1:0] w_md_result;

  assign w_go_busy = w_accept && op_is_muldiv(w_op);
  assign busy      = (r_state == BUSY);

  alu_muldiv_iter #(.N(N)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (w_go_busy),
    .op     (w_op),
    .a      (SrcA),
    .b      (SrcB),
    .done   (w_md_done),
    .result (w_md_result)
  );
`else
  assign w_go_busy = 1'b0;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_go_busy) begin
            r_state     <= BUSY;
            r_out_valid <= 1'b0;
          end else if (w_accept) begin
            r_state     <= DONE;
            r_result    <= w_simple;
            r_zero      <= (w_simple == '0);
            r_out_valid <= 1'b1;
          end else if ((r_state == DONE) && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          if (w_md_done) begin
            r_state     <= DONE;
            r_result    <= w_md_result;
            r_zero      <= (w_md_result == '0);
            r_out_valid <= 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign zero_flag = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq, follows ALU_SEQ_MULDIV_EN if defined
module tb_alu_seq;

  localparam int  N = 32;
  localparam time P = 10;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] SrcA = '0;
  logic [N-1:0] SrcB = '0;
  logic [3:0]   ALUControl = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] ALUResult;
  logic         zero_flag;
  logic         busy;

  alu_seq #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .zero_flag  (zero_flag),
    .busy       (busy)
  );

  always #(P/2) clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    time          t_exp;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   seen = 1'b0;
  time  first_t = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic bit is_md(input int op);
    return MD && (op >= 10) && (op <= 13);
  endfunction

  // Reference: plain integer arithmetic on the operation's definition
  function automatic logic [N-1:0] model(input int op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [63:0] p;
    int          sh;
    p  = 64'(a) * 64'(b);
    sh = int'(b % N);
    if (op >= 10 && op <= 13 && !MD) return '0;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ($signed(a) < $signed(b)) ? 1 : 0;
      6:  return (a < b) ? 1 : 0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return $signed(a) >>> sh;
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? '1 : a / b;
      13: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  task automatic push_exp(input int op, input logic [N-1:0] a, input logic [N-1:0] b, input time t_acc);
    exp_t e;
    e.res   = model(op, a, b);
    e.t_exp = t_acc + (is_md(op) ? N * P : 0) + P/2;
    e.tag   = $sformatf("op%0d_%0h_%0h", op, a, b);
    sb.push_back(e);
  endtask

  task automatic set_ready(input int rmode);
    if (rmode == 0) out_ready = 1'b0;
    else if (rmode == 1) out_ready = 1'b1;
    else out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input int op, input logic [N-1:0] a, input logic [N-1:0] b, input int rmode);
    int w;
    w = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; ALUControl = 4'(op); SrcA = a; SrcB = b;
    set_ready(rmode); #1;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      set_ready(rmode); #1;
      w++;
    end
    check("issue_accepted", in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      push_exp(op, a, b, $time);
      #1;
      SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic busy_window();
`ifdef ALU_SEQ_MULDIV_EN
    bit bad;
    bad = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
    end
    check("busy_window", bad, 0);
`else
    @(negedge clk);
    check("busy_tied_low", busy, 0);
`endif
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen    = 1'b1;
        first_t = $time;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_output", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_result"}, ALUResult, e.res);
          check({e.tag, "_zero"}, zero_flag, (e.res == 0));
          check({e.tag, "_latency"}, first_t, e.t_exp);
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit bad_hold;
    bit bad_acc;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", ALUResult, 0);
    check("reset_zero_flag", zero_flag, 1);
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);

    issue(1, 5, 5, 1);
    issue(5, 32'hFFFF_FFFF, 1, 1);
    issue(6, 32'hFFFF_FFFF, 1, 1);
    issue(9, 32'h8000_0000, 4, 1);
    issue(10, 32'h0001_0000, 32'h0001_0000, 1);
    busy_window();
    issue(11, 32'h0001_0000, 32'h0001_0000, 1);
    busy_window();
    issue(12, 100, 7, 1);
    busy_window();
    issue(13, 100, 7, 1);
    issue(12, 9, 0, 1);
    issue(13, 9, 0, 1);
    drain();

    issue(0, 3, 4, 0);
    in_valid = 1'b1; ALUControl = 4'd0; SrcA = 10; SrcB = 20;
    bad_hold = 1'b0;
    bad_acc  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || ALUResult !== 7) bad_hold = 1'b1;
      if (in_ready !== 1'b0) bad_acc = 1'b1;
    end
    check("bp_hold_stable", bad_hold, 0);
    check("bp_not_accepted", bad_acc, 0);
    @(posedge clk); #1;
    out_ready = 1'b1; #1;
    check("bp_accept_same_cycle", in_ready, 1);
    @(posedge clk);
    push_exp(0, 10, 20, $time);
    #1 in_valid = 1'b0;

    issue(12, 100, 7, 1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_busy", busy, 0);
    issue(0, 1, 1, 1);
    issue(10, 3, 3, 1);
    busy_window();
    drain();

    for (int i = 0; i < 150; i++) begin
      int           op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      op = $urandom_range(0, 15);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 40);
        2: b = '0;
        default: b = a;
      endcase
      issue(op, a, b, 2);
    end
    drain();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
